// File: rtl/k285_pkg.sv
// Shared K28.5 serializer definitions: symbol width, comma patterns and FSM state type.
package k285_pkg;

  localparam int SYM_W = 10;
  localparam int BC_W  = 4;

  localparam logic [SYM_W-1:0] K285_NEG = 10'b0011111010;
  localparam logic [SYM_W-1:0] K285_POS = 10'b1100000101;

  typedef enum logic {
    SYNC = 1'b0,
    DATA = 1'b1
  } state_t;

endpackage

// File: rtl/k285_serializer_if.sv
// Symbol-in / serial-out bus of the K28.5 serializer; slave is the serializer side.
interface k285_serializer_if;
  import k285_pkg::*;

  logic [SYM_W-1:0] datos;
  logic             valido;
  logic             listo;
  logic             salida;
  logic             inicio;

  modport master (
    output datos,
    output valido,
    input  listo,
    input  salida,
    input  inicio
  );

  modport slave (
    input  datos,
    input  valido,
    output listo,
    output salida,
    output inicio
  );

endinterface

// File: rtl/k285_piso.sv
// 10-bit parallel-load / shift-left register; MSB is the serial output.
module k285_piso
  import k285_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic             i_shift,
  input  logic [SYM_W-1:0] i_data,
  output logic             o_msb
);

  logic [SYM_W-1:0] r_sh;

  // Load has priority over shift; neither means hold.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sh <= '0;
    end else if (i_load) begin
      r_sh <= i_data;
    end else if (i_shift) begin
      r_sh <= {r_sh[SYM_W-2:0], 1'b0};
    end
  end

  assign o_msb = r_sh[SYM_W-1];

endmodule

// File: rtl/k285_serializer.sv
// K28.5 comma-framed symbol serializer: SYNC_COMMAS commas after reset, then data or fill commas.
// Optional macro K285_RD_ALT_EN alternates comma disparity (NEG/POS); otherwise every comma is K285_NEG.
module k285_serializer
  import k285_pkg::*;
#(
  parameter int SYNC_COMMAS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enb,
  k285_serializer_if.slave bus
);

  localparam logic [BC_W-1:0] BC_LAST = BC_W'(SYM_W - 1);
  localparam logic [BC_W-1:0] CC_LAST = BC_W'(SYNC_COMMAS);

  if (SYNC_COMMAS < 1 || SYNC_COMMAS > 15) begin : g_bad_sync_commas
    $error("SYNC_COMMAS must be in 1..15");
  end

  state_t           r_state;
  state_t           w_state_nxt;
  logic [BC_W-1:0]  r_bc;
  logic [BC_W-1:0]  w_bc_nxt;
  logic [BC_W-1:0]  r_cc;
  logic [BC_W-1:0]  w_cc_nxt;
  logic             r_inicio;
  logic             w_inicio_nxt;
  logic             w_load;
  logic             w_shift;
  logic             w_slot_data;
  logic             w_listo;
  logic             w_take;
  logic [SYM_W-1:0] w_comma;
  logic [SYM_W-1:0] w_sym;
  logic             w_salida;

`ifdef K285_RD_ALT_EN
  logic r_rd;
  logic w_rd_nxt;

  // Disparity flips only when a comma is loaded; data symbols leave it alone.
  assign w_rd_nxt = r_rd ^ (w_load & ~w_take);
  assign w_comma  = r_rd ? K285_POS : K285_NEG;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd <= 1'b0;
    end else begin
      r_rd <= w_rd_nxt;
    end
  end
`else
  assign w_comma = K285_NEG;
`endif

  // The next load is a data slot once the last sync comma is on the wire.
  assign w_slot_data = (r_state == DATA) || (r_cc == CC_LAST);
  assign w_load      = enb && (r_bc == BC_LAST);
  assign w_shift     = enb && (r_bc != BC_LAST);
  assign w_listo     = w_load && w_slot_data;
  assign w_take      = w_listo && bus.valido;
  assign w_sym       = w_take ? bus.datos : w_comma;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= SYNC;
      r_bc     <= BC_LAST;
      r_cc     <= '0;
      r_inicio <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_bc     <= w_bc_nxt;
      r_cc     <= w_cc_nxt;
      r_inicio <= w_inicio_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_bc_nxt     = r_bc;
    w_cc_nxt     = r_cc;
    w_inicio_nxt = r_inicio;
    if (w_load) begin
      w_bc_nxt     = '0;
      w_inicio_nxt = 1'b1;
      if (w_slot_data) begin
        w_state_nxt = DATA;
      end else begin
        w_cc_nxt = r_cc + 1'b1;
      end
    end else if (w_shift) begin
      w_bc_nxt     = r_bc + 1'b1;
      w_inicio_nxt = 1'b0;
    end
  end

  k285_piso u_piso (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_load),
    .i_shift (w_shift),
    .i_data  (w_sym),
    .o_msb   (w_salida)
  );

  assign bus.salida = w_salida;
  assign bus.inicio = r_inicio;
  assign bus.listo  = w_listo;

  a_listo_at_last_bit : assert property (@(posedge clk) disable iff (!rst)
    bus.listo |-> (r_bc == BC_LAST));
  a_inicio_at_first_bit : assert property (@(posedge clk) disable iff (!rst)
    bus.inicio |-> (r_bc == '0));

endmodule

// File: tb/tb_k285_serializer.sv
// Scoreboard bench for k285_serializer: stimulus queues expected symbols, a monitor deserializes salida.
`timescale 1ns/1ps
module tb_k285_serializer;
  import k285_pkg::*;

  localparam int NSYNC = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic enb = 1'b0;

  k285_serializer_if bus ();

  k285_serializer #(.SYNC_COMMAS(NSYNC)) dut (
    .clk (clk),
    .rst (rst),
    .enb (enb),
    .bus (bus)
  );

  initial forever #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [SYM_W-1:0] expq[$];
  bit tb_rd = 1'b0;
  int sl = 0;

  bit en_edge = 1'b0;
  int nbits = 0;
  int winfill = 0;
  int det_hits = 0;
  int comma_done = 0;
  logic [SYM_W-1:0] shreg = '0;
  logic [SYM_W-1:0] win = '0;
  logic [SYM_W-1:0] exp_sym;
  bit det_hit_now;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [SYM_W-1:0] next_comma();
    logic [SYM_W-1:0] c;
    c = tb_rd ? K285_POS : K285_NEG;
`ifdef K285_RD_ALT_EN
    tb_rd = ~tb_rd;
`endif
    return c;
  endfunction

  // Records whether the DUT actually advanced on this edge.
  initial forever begin
    @(posedge clk);
    en_edge = enb && rst;
  end

  // Monitor: rebuild symbols from salida, framed by inicio, and pop expectations.
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      nbits   = 0;
      winfill = 0;
    end else if (en_edge) begin
      win = {win[SYM_W-2:0], bus.salida};
      if (winfill < SYM_W) winfill++;
      det_hit_now = (winfill == SYM_W) && (win == K285_NEG || win == K285_POS);
      if (det_hit_now) det_hits++;
      if (bus.inicio) begin
        chk("sym_align", 32'(nbits), 32'd0);
        nbits = 0;
      end
      shreg = {shreg[SYM_W-2:0], bus.salida};
      nbits++;
      if (nbits == SYM_W) begin
        if (expq.size() == 0) begin
          chk("sb_empty", 32'd1, 32'd0);
        end else begin
          exp_sym = expq.pop_front();
          chk("symbol", 32'(shreg), 32'(exp_sym));
          chk("esk285", 32'(det_hit_now), 32'(exp_sym == K285_NEG || exp_sym == K285_POS));
          if (exp_sym == K285_NEG || exp_sym == K285_POS) comma_done++;
        end
        nbits = 0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Assert reset, check outputs at once, hold a few cycles, release away from the edge.
  task automatic hold_reset();
    rst = 1'b0;
    enb = 1'b1;
    bus.valido = 1'b0;
    #1;
    chk("rst_salida", 32'(bus.salida), 32'd0);
    chk("rst_inicio", 32'(bus.inicio), 32'd0);
    chk("rst_listo",  32'(bus.listo),  32'd0);
    expq.delete();
    tb_rd = 1'b0;
    sl = 0;
    repeat (3) step();
    chk("rst_hold_salida", 32'(bus.salida), 32'd0);
    rst = 1'b1;
  endtask

  // One symbol slot starting at bc==9; frz freezes enb for 7 cycles at that bc; abrt returns at that bc.
  task automatic do_slot(input bit vld, input logic [SYM_W-1:0] d, input int frz, input int abrt);
    bit exp_l;
    logic hs;
    logic hi;
    exp_l = (sl >= NSYNC);
    bus.valido = vld;
    bus.datos  = d;
    #1;
    chk("listo_slot", 32'(bus.listo), 32'(exp_l));
    if (vld && exp_l) expq.push_back(d);
    else              expq.push_back(next_comma());
    sl++;
    for (int k = 1; k <= SYM_W; k++) begin
      step();
      chk("inicio", 32'(bus.inicio), 32'(k == 1));
      if (k < SYM_W) chk("listo_mid", 32'(bus.listo), 32'd0);
      if (k - 1 == abrt) return;
      if (k - 1 == frz) begin
        hs  = bus.salida;
        hi  = bus.inicio;
        enb = 1'b0;
        #1;
        chk("listo_frozen", 32'(bus.listo), 32'd0);
        repeat (7) begin
          step();
          chk("frz_salida", 32'(bus.salida), 32'(hs));
          chk("frz_inicio", 32'(bus.inicio), 32'(hi));
          chk("frz_listo",  32'(bus.listo),  32'd0);
        end
        enb = 1'b1;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.datos  = '0;
    bus.valido = 1'b0;

    // Idle link: sync commas then fill commas, each detected exactly once.
    hold_reset();
    det_hits   = 0;
    comma_done = 0;
    for (int s = 0; s < 7; s++) do_slot(1'b0, 10'h000, -1, -1);
    chk("det_count", 32'(det_hits), 32'(comma_done));
    chk("commas_done", 32'(comma_done), 32'd6);

    // valido held from reset: first transfer only at the end of the 4th sync comma.
    hold_reset();
    for (int s = 0; s < NSYNC; s++) do_slot(1'b1, 10'b1010110001, -1, -1);
    do_slot(1'b1, 10'b1010110001, -1, -1);
    do_slot(1'b1, 10'b0110100101, -1, -1);
    do_slot(1'b0, 10'b0110100101, -1, -1);

    // valido toggling per slot, including a comma-valued data symbol.
    do_slot(1'b1, 10'b1110001011, -1, -1);
    do_slot(1'b0, 10'b0000000000, -1, -1);
    do_slot(1'b1, K285_POS,       -1, -1);
    do_slot(1'b0, 10'b0000000000, -1, -1);
    do_slot(1'b1, 10'b1111000011, -1, -1);
    do_slot(1'b0, 10'b0000000000, -1, -1);

    // enb pause of 7 cycles at bc==4 stretches the symbol to 17 cycles.
    do_slot(1'b1, 10'b1001011100, 4, -1);
    do_slot(1'b1, 10'b0101100110, -1, -1);

    // Reset in the middle of a data symbol at bc==6, then full resync.
    do_slot(1'b1, 10'b0101010111, -1, 6);
    hold_reset();
    for (int s = 0; s < NSYNC + 2; s++) do_slot(1'b0, 10'h000, -1, -1);
    chk("queue_drain", 32'(expq.size()), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
